cache_axi_rd_arbiter: RTL and testbench
=======================================

CACHE_AXI_RD_ARBITER -- requirements
Module: cache_axi_rd_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have icache request ports i_req in 1, i_addr in 32, i_len in 8 (beats-1), i_cancel in 1.
REQ-004 SHALL have icache response ports i_gnt out 1, i_rvalid out 1, i_rdata out 32, i_rlast out 1.
REQ-005 SHALL have dcache request ports d_req in 1, d_addr in 32, d_len in 8.
REQ-006 SHALL have dcache response ports d_gnt out 1, d_rvalid out 1, d_rdata out 32, d_rlast out 1.
REQ-007 SHALL have AXI AR ports arvalid out 1, araddr out 32, arlen out 8, arid out 4, arsize out 3, arburst out 2, arready in 1.
REQ-008 SHALL have AXI R ports rvalid in 1, rdata in 32, rlast in 1, rready out 1.
REQ-009 SHALL have status ports busy out 1 (state != IDLE) and len_err out 1 (one-cycle pulse).

Function
REQ-010 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE, one outstanding AXI read at a time.
REQ-011 In IDLE, any req high SHALL select an owner, latch its addr/len, and enter ADDR next cycle; arvalid is first high in the cycle after req is sampled.
REQ-012 Tie (i_req & d_req) SHALL resolve per REQ-030/031; a single requester is always granted.
REQ-013 In ADDR, arvalid SHALL be 1 with araddr/arlen/arid stable until arready; arid = 0 for icache, 1 for dcache; arsize = 3'b010, arburst = 2'b01 constant.
REQ-014 The owner's gnt SHALL pulse high exactly in the cycle arvalid & arready; FSM then enters DATA.
REQ-015 In DATA, rready SHALL be 1; each rvalid beat SHALL drive owner's rvalid/rdata/rlast combinationally same cycle; non-owner rvalid stays 0.
REQ-016 An 8-bit beat counter SHALL clear on entering DATA and increment per accepted beat.
REQ-017 On rvalid & rlast, FSM SHALL return to IDLE; if counter != latched len, len_err SHALL pulse that cycle.
REQ-018 Requests SHALL be sampled only in IDLE; requester holds req until its gnt; at least one IDLE cycle separates bursts.
REQ-019 i_cancel high while owner = icache in ADDR or DATA SHALL set a sticky cancel flag; AR handshake still completes, all remaining beats still accepted (rready=1) but i_rvalid/i_rlast forced 0.
REQ-020 Cancel flag SHALL clear on return to IDLE; i_cancel in IDLE or with owner = dcache is ignored.
REQ-021 i_gnt SHALL still pulse on AR handshake when cancelled.
REQ-022 rvalid outside DATA SHALL be ignored and rready held 0.

Reset
REQ-023 rst SHALL force FSM to IDLE, clear owner, cancel flag, beat counter, latched addr/len, priority pointer (last owner = icache).
REQ-024 During and after reset until a new request: arvalid, rready, i_gnt, d_gnt, i_rvalid, d_rvalid, i_rlast, d_rlast, busy, len_err = 0; araddr, arlen, arid = 0.
REQ-025 rst asserted mid-ADDR or mid-DATA SHALL abort immediately to IDLE with no further gnt/rvalid pulses.

Configuration
REQ-030 With ARB_ROUND_ROBIN_EN defined, ties SHALL grant the requester not granted last; pointer updates on each gnt.
REQ-031 Without ARB_ROUND_ROBIN_EN, ties SHALL always grant dcache.

Verification
REQ-040 i_req, i_addr=0x1FC00000, i_len=3, arready delayed 2 cycles, 4 beats -> arvalid 1 cycle after req, i_gnt on handshake, 4 i_rvalid, i_rlast on beat 4, busy drops next cycle.
REQ-041 i_req and d_req same cycle, both len=0, repeated twice -> fixed mode: dcache, dcache; ARB_ROUND_ROBIN_EN: dcache then icache.
REQ-042 icache burst len=7, i_cancel pulse after beat 2 -> beats 3-8 accepted with rready=1, i_rvalid=0, FSM reaches IDLE after rlast.
REQ-043 d_len=3 but rlast on beat 2 -> len_err pulses once, FSM to IDLE, no hang.
REQ-044 rst in DATA after beat 1 of len=3 burst -> next cycle all outputs 0, state IDLE, rvalid then ignored.
REQ-045 rvalid pulse while IDLE -> rready=0, no i_rvalid/d_rvalid.

Source files
------------

// File: rtl/cache_axi_rd_arbiter.sv
// Two-port (icache/dcache) read arbiter onto a single AXI read channel, one burst in flight.
// Optional ARB_ROUND_ROBIN_EN: ties alternate between requesters instead of always favouring dcache.
module cache_axi_rd_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_len,
  input  logic        i_cancel,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [7:0]  d_len,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        arvalid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [3:0]  arid,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  output logic        rready,
  output logic        busy,
  output logic        len_err
);

  // state | meaning
  // IDLE  | no burst; requests sampled and owner chosen here
  // ADDR  | AR channel presented for the owner, waiting on arready
  // DATA  | R beats accepted and routed to the owner until rlast
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state, state_nxt;
  logic        owner;        // 1 = dcache
  logic        last_owner;
  logic        cancel_q;
  logic [7:0]  beat_cnt;
  logic [7:0]  len_q;
  logic [31:0] addr_q;
  logic        pick_d;
  logic        ar_hs;
  logic        beat;
  logic        i_masked;

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pick_d = d_req & (~i_req | ~last_owner);
`else
    pick_d = d_req;
`endif
  end

  assign ar_hs    = (state == ADDR) & arready;
  assign beat     = (state == DATA) & rvalid;
  // A cancel masks the icache response in the very cycle it is raised, not just afterwards.
  assign i_masked = (state != IDLE) & ~owner & (cancel_q | i_cancel);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req | d_req)  state_nxt = ADDR;
      ADDR:    if (arready)        state_nxt = DATA;
      DATA:    if (rvalid & rlast) state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= 1'b0;
      last_owner <= 1'b0;
      cancel_q   <= 1'b0;
      beat_cnt   <= 8'd0;
      len_q      <= 8'd0;
      addr_q     <= 32'd0;
    end else begin
      if ((state == IDLE) & (i_req | d_req)) begin
        owner  <= pick_d;
        addr_q <= pick_d ? d_addr : i_addr;
        len_q  <= pick_d ? d_len  : i_len;
      end
      if (ar_hs) begin
        last_owner <= owner;
        beat_cnt   <= 8'd0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      if (state == IDLE)          cancel_q <= 1'b0;
      else if (~owner & i_cancel) cancel_q <= 1'b1;
    end
  end

  // Outputs are gated by rst so an abort is visible in the reset cycle itself.
  always_comb begin
    arvalid  = 1'b0;
    araddr   = 32'd0;
    arlen    = 8'd0;
    arid     = 4'd0;
    arsize   = 3'b010;
    arburst  = 2'b01;
    rready   = 1'b0;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    i_rlast  = 1'b0;
    d_rlast  = 1'b0;
    i_rdata  = 32'd0;
    d_rdata  = 32'd0;
    busy     = 1'b0;
    len_err  = 1'b0;
    if (!rst) begin
      arvalid  = (state == ADDR);
      araddr   = addr_q;
      arlen    = len_q;
      arid     = {3'b000, owner};
      rready   = (state == DATA);
      i_gnt    = ar_hs & ~owner;
      d_gnt    = ar_hs & owner;
      i_rvalid = beat & ~owner & ~i_masked;
      d_rvalid = beat & owner;
      i_rlast  = i_rvalid & rlast;
      d_rlast  = d_rvalid & rlast;
      i_rdata  = i_rvalid ? rdata : 32'd0;
      d_rdata  = d_rvalid ? rdata : 32'd0;
      busy     = (state != IDLE);
      len_err  = beat & rlast & (beat_cnt != len_q);
    end
  end

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Bench for cache_axi_rd_arbiter: directed vector table, reset corner sequences, and random
// transactions checked against a transaction-level model of arbitration and burst delivery.
module tb_cache_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_cancel, d_req;
  logic [31:0] i_addr, d_addr;
  logic [7:0]  i_len, d_len;
  logic        i_gnt, i_rvalid, i_rlast, d_gnt, d_rvalid, d_rlast;
  logic [31:0] i_rdata, d_rdata;
  logic        arvalid, arready, rvalid, rlast, rready, busy, len_err;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [3:0]  arid;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  always #5 clk = ~clk;

  cache_axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_cancel(i_cancel),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast),
    .d_req(d_req), .d_addr(d_addr), .d_len(d_len),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast),
    .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arid(arid),
    .arsize(arsize), .arburst(arburst), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rready(rready),
    .busy(busy), .len_err(len_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit rr_mode;
  bit last_d;   // model: previous grant went to dcache

  typedef struct {
    bit          ir, dr;
    logic [31:0] ia, da;
    logic [7:0]  il, dl;
    int          ar_dly, nbeats, cancel_at;
    bit          own_fix, own_rr, lerr, gaps;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_req = 0; d_req = 0; i_cancel = 0; arready = 0; rvalid = 0; rlast = 0;
    i_addr = 0; d_addr = 0; i_len = 0; d_len = 0; rdata = 0;
  endtask

  task automatic check_quiet(input string name);
    chk(name, {arvalid, rready, i_gnt, d_gnt, i_rvalid, d_rvalid, i_rlast, d_rlast, busy, len_err}, 0);
  endtask

  // cancel_at: -1 none, -2 during first ADDR cycle, n>=0 in a gap right after beat index n
  task automatic run_txn(input bit ir, input bit dr, input logic [31:0] ia, input logic [31:0] da,
                         input logic [7:0] il, input logic [7:0] dl, input int ar_dly,
                         input int nbeats, input int cancel_at, input bit exp_owner,
                         input bit exp_lerr, input bit gaps);
    logic [31:0] exp_addr;
    logic [7:0]  exp_len;
    bit          cancelled, cancel_done, gap, iv, dv;
    int          nb;
    exp_addr = exp_owner ? da : ia;
    exp_len  = exp_owner ? dl : il;
    cancelled = 0; cancel_done = 0; nb = 0;

    i_req = ir; d_req = dr; i_addr = ia; d_addr = da; i_len = il; d_len = dl;
    samp();
    chk("idle_arvalid", arvalid, 0);
    chk("idle_busy", busy, 0);
    step();

    for (int k = 0; k <= ar_dly; k++) begin
      arready  = (k == ar_dly);
      i_cancel = (cancel_at == -2) && (k == 0);
      if (i_cancel && !exp_owner) cancelled = 1;
      samp();
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, exp_addr);
      chk("arlen", arlen, exp_len);
      chk("arid", arid, {3'b000, exp_owner});
      chk("arsize_arburst", {arsize, arburst}, {3'b010, 2'b01});
      chk("i_gnt", i_gnt, (k == ar_dly) && !exp_owner);
      chk("d_gnt", d_gnt, (k == ar_dly) && exp_owner);
      chk("addr_rready", rready, 0);
      step();
    end
    i_req = 0; d_req = 0; arready = 0; i_cancel = 0;
    last_d = exp_owner;

    while (nb < nbeats) begin
      gap = gaps && ($urandom_range(0, 2) == 0);
      if (cancel_at >= 0 && !cancel_done && nb == cancel_at + 1) begin
        gap = 1; i_cancel = 1; cancel_done = 1;
        if (!exp_owner) cancelled = 1;
      end
      rvalid = !gap;
      rlast  = !gap && (nb == nbeats - 1);
      rdata  = $urandom;
      samp();
      chk("data_rready", rready, 1);
      chk("data_busy", busy, 1);
      if (rvalid) begin
        iv = !exp_owner && !cancelled;
        dv = exp_owner;
        chk("i_rvalid", i_rvalid, iv);
        chk("d_rvalid", d_rvalid, dv);
        chk("i_rlast", i_rlast, iv && rlast);
        chk("d_rlast", d_rlast, dv && rlast);
        if (iv) chk("i_rdata", i_rdata, rdata);
        if (dv) chk("d_rdata", d_rdata, rdata);
        chk("len_err", len_err, rlast && exp_lerr);
      end else begin
        chk("gap_rvalid", {i_rvalid, d_rvalid, len_err}, 0);
      end
      step();
      if (rvalid) nb++;
      i_cancel = 0;
    end
    rvalid = $urandom_range(0, 1);
    rlast  = rvalid;
    rdata  = $urandom;
    samp();
    check_quiet("post_idle");
    step();
    rvalid = 0; rlast = 0;
  endtask

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    rr_mode = 1;
`else
    rr_mode = 0;
`endif
    tbl[0] = '{1, 0, 32'h1FC0_0000, 32'h0, 8'd3, 8'd0, 2, 4,   -1, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 32'h0000_1000, 32'h8000_2000, 8'd0, 8'd0, 0, 1, -1, 1, 1, 0, 0};
    tbl[2] = '{1, 1, 32'h0000_1040, 32'h8000_2040, 8'd0, 8'd0, 1, 1, -1, 1, 0, 0, 0};
    tbl[3] = '{1, 0, 32'h0000_3000, 32'h0, 8'd7, 8'd0, 1, 8,    1, 0, 0, 0, 1};
    tbl[4] = '{0, 1, 32'h0, 32'h8000_4000, 8'd0, 8'd3, 0, 2,   -1, 1, 1, 1, 1};
    tbl[5] = '{0, 1, 32'h0, 32'h8000_5000, 8'd0, 8'd0, 0, 1,   -1, 1, 1, 0, 0};
    tbl[6] = '{1, 0, 32'h0000_6000, 32'h0, 8'd255, 8'd0, 3, 256, -1, 0, 0, 0, 0};
    tbl[7] = '{1, 0, 32'h0000_7000, 32'h0, 8'd2, 8'd0, 2, 3,   -2, 0, 0, 0, 1};
    tbl[8] = '{0, 1, 32'h0, 32'h8000_8000, 8'd0, 8'd1, 0, 2,    0, 1, 1, 0, 1};
    tbl[9] = '{0, 1, 32'h0, 32'h8000_9000, 8'd0, 8'd1, 1, 3,   -1, 1, 1, 1, 0};

    idle_inputs();
    rst = 1; i_req = 1; rvalid = 1; arready = 1;
    for (int c = 0; c < 3; c++) begin
      samp();
      check_quiet("reset_outputs");
      chk("reset_ar_fields", {araddr, arlen, arid}, 0);
      step();
    end
    idle_inputs();
    rst = 0; last_d = 0;
    samp();
    check_quiet("after_reset");
    chk("after_reset_ar_fields", {araddr, arlen, arid}, 0);
    step();

    foreach (tbl[v])
      run_txn(tbl[v].ir, tbl[v].dr, tbl[v].ia, tbl[v].da, tbl[v].il, tbl[v].dl, tbl[v].ar_dly,
              tbl[v].nbeats, tbl[v].cancel_at, rr_mode ? tbl[v].own_rr : tbl[v].own_fix,
              tbl[v].lerr, tbl[v].gaps);

    // reset in DATA after first beat of a 4-beat icache burst
    i_req = 1; i_addr = 32'h0000_A000; i_len = 3;
    step();
    arready = 1;
    step();
    i_req = 0; arready = 0; rvalid = 1; rdata = 32'hDEAD_0001;
    samp();
    chk("pre_rst_i_rvalid", i_rvalid, 1);
    step();
    rst = 1; rdata = 32'hDEAD_0002;
    samp();
    check_quiet("rst_in_data");
    step();
    rst = 0; rlast = 1;
    samp();
    check_quiet("rvalid_after_rst");
    step();
    rvalid = 0; rlast = 0; last_d = 0;

    // reset in ADDR must suppress the pending grant
    d_req = 1; d_addr = 32'h8000_B000; d_len = 1;
    step();
    d_req = 0;
    samp();
    chk("pre_rst_arvalid", arvalid, 1);
    step();
    rst = 1; arready = 1;
    samp();
    check_quiet("rst_in_addr");
    step();
    rst = 0; arready = 0;
    samp();
    check_quiet("after_addr_rst");
    step();
    last_d = 0;

    // stray rvalid in IDLE
    rvalid = 1; rlast = 1; rdata = 32'h1234_5678;
    samp();
    check_quiet("idle_stray_rvalid");
    step();
    rvalid = 0; rlast = 0;

    for (int t = 0; t < 40; t++) begin
      int pat, ard, nbt, cat;
      logic [7:0] il, dl, len;
      bit own;
      pat = $urandom_range(1, 3);
      il  = 8'($urandom_range(0, 6));
      dl  = 8'($urandom_range(0, 6));
      ard = $urandom_range(0, 3);
      if (pat == 3) own = rr_mode ? !last_d : 1'b1;
      else          own = (pat == 2);
      len = own ? dl : il;
      nbt = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8) : int'(len) + 1;
      cat = -1;
      if ($urandom_range(0, 3) == 0)
        cat = (nbt < 2 || $urandom_range(0, 2) == 0) ? -2 : $urandom_range(0, nbt - 2);
      run_txn(pat[0], pat[1], $urandom, $urandom, il, dl, ard, nbt, cat, own,
              (nbt - 1) != int'(len), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
